// File: rtl/lcd_spi_sink.sv
// lcd_spi_sink: receive side of the 4-wire panel link.
// Decodes CASET/RASET/RAMWR into addressed RGB565 pixel writes.
module lcd_spi_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda,
  input  logic        cs,
  input  logic        rs,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        err
);

  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [7:0] YMAX = 8'(HEIGHT - 1);
  localparam logic [8:0] WLIM = 9'(WIDTH);
  localparam logic [8:0] HLIM = 9'(HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_RASET,
    S_RAMWR,
    S_IGNORE
  } state_t;

  logic scl_m, scl_s, scl_q;
  logic sda_m, sda_s;
  logic cs_m, cs_s;
  logic rs_m, rs_s;
  logic scl_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_m <= 1'b0;
      scl_s <= 1'b0;
      scl_q <= 1'b0;
      sda_m <= 1'b0;
      sda_s <= 1'b0;
      cs_m  <= 1'b1;
      cs_s  <= 1'b1;
      rs_m  <= 1'b0;
      rs_s  <= 1'b0;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      scl_q <= scl_s;
      sda_m <= sda;
      sda_s <= sda_m;
      cs_m  <= cs;
      cs_s  <= cs_m;
      rs_m  <= rs;
      rs_s  <= rs_m;
    end
  end

  assign scl_rise = scl_s & ~scl_q;

  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] rx_byte;
  logic       rx_rs;
  logic       rx_got;
  logic       cs_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
      rx_byte <= 8'd0;
      rx_rs   <= 1'b0;
      rx_got  <= 1'b0;
      cs_err  <= 1'b0;
    end else begin
      rx_got <= 1'b0;
      cs_err <= 1'b0;
      if (cs_s) begin
        bit_cnt <= 3'd0;
        cs_err  <= (bit_cnt != 3'd0);
      end else if (scl_rise) begin
        shreg   <= {shreg[5:0], sda_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte <= {shreg, sda_s};
          rx_rs   <= rs_s;
          rx_got  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_valid   <= 1'b0;
      byte_data    <= 8'd0;
      byte_is_data <= 1'b0;
    end else begin
      byte_valid <= rx_got;
      if (rx_got) begin
        byte_data    <= rx_byte;
        byte_is_data <= rx_rs;
      end
    end
  end

  state_t      state, state_n;
  logic [1:0]  pidx, pidx_n;
  logic [7:0]  p_sh, p_sh_n;
  logic [7:0]  p_sl, p_sl_n;
  logic [7:0]  p_eh, p_eh_n;
  logic [7:0]  xs, xs_n, xe, xe_n;
  logic [7:0]  ys, ys_n, ye, ye_n;
  logic [7:0]  cx, cx_n, cy, cy_n;
  logic        have_hi, have_hi_n;
  logic [7:0]  hi, hi_n;
  logic        pix_valid_n, frame_done_n, err_n;
  logic [7:0]  pix_x_n, pix_y_n;
  logic [15:0] pix_data_n;
  logic [8:0]  lim;
  logic        win_ok;

  // End bound is checked in 9 bits so a 256-wide panel still works.
  assign lim    = (state == S_CASET) ? WLIM : HLIM;
  assign win_ok = (p_sh == 8'd0) && (p_eh == 8'd0) &&
                  (p_sl <= byte_data) &&
                  ({1'b0, byte_data} < lim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pidx       <= 2'd0;
      p_sh       <= 8'd0;
      p_sl       <= 8'd0;
      p_eh       <= 8'd0;
      xs         <= 8'd0;
      xe         <= XMAX;
      ys         <= 8'd0;
      ye         <= YMAX;
      cx         <= 8'd0;
      cy         <= 8'd0;
      have_hi    <= 1'b0;
      hi         <= 8'd0;
      pix_valid  <= 1'b0;
      pix_x      <= 8'd0;
      pix_y      <= 8'd0;
      pix_data   <= 16'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      pidx       <= pidx_n;
      p_sh       <= p_sh_n;
      p_sl       <= p_sl_n;
      p_eh       <= p_eh_n;
      xs         <= xs_n;
      xe         <= xe_n;
      ys         <= ys_n;
      ye         <= ye_n;
      cx         <= cx_n;
      cy         <= cy_n;
      have_hi    <= have_hi_n;
      hi         <= hi_n;
      pix_valid  <= pix_valid_n;
      pix_x      <= pix_x_n;
      pix_y      <= pix_y_n;
      pix_data   <= pix_data_n;
      frame_done <= frame_done_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    pidx_n       = pidx;
    p_sh_n       = p_sh;
    p_sl_n       = p_sl;
    p_eh_n       = p_eh;
    xs_n         = xs;
    xe_n         = xe;
    ys_n         = ys;
    ye_n         = ye;
    cx_n         = cx;
    cy_n         = cy;
    have_hi_n    = have_hi;
    hi_n         = hi;
    pix_valid_n  = 1'b0;
    pix_x_n      = pix_x;
    pix_y_n      = pix_y;
    pix_data_n   = pix_data;
    frame_done_n = 1'b0;
    err_n        = cs_err;
    if (byte_valid && !byte_is_data) begin
      pidx_n    = 2'd0;
      have_hi_n = 1'b0;
      unique case (1'b1)
        (byte_data == 8'h2A): state_n = S_CASET;
        (byte_data == 8'h2B): state_n = S_RASET;
        (byte_data == 8'h2C): begin
          state_n = S_RAMWR;
          cx_n    = xs;
          cy_n    = ys;
        end
        default: state_n = S_IGNORE;
      endcase
    end else if (byte_valid) begin
      case (state)
        S_CASET, S_RASET: begin
          pidx_n = pidx + 2'd1;
          case (pidx)
            2'd0: p_sh_n = byte_data;
            2'd1: p_sl_n = byte_data;
            2'd2: p_eh_n = byte_data;
            default: begin
              state_n = S_IGNORE;
              if (!win_ok) begin
                err_n = 1'b1;
              end else if (state == S_CASET) begin
                xs_n = p_sl;
                xe_n = byte_data;
              end else begin
                ys_n = p_sl;
                ye_n = byte_data;
              end
            end
          endcase
        end
        S_RAMWR: begin
          if (!have_hi) begin
            hi_n      = byte_data;
            have_hi_n = 1'b1;
          end else begin
            have_hi_n   = 1'b0;
            pix_valid_n = 1'b1;
            pix_x_n     = cx;
            pix_y_n     = cy;
            pix_data_n  = {hi, byte_data};
            if (cx < xe) begin
              cx_n = cx + 8'd1;
            end else if (cy < ye) begin
              cx_n = xs;
              cy_n = cy + 8'd1;
            end else begin
              cx_n         = xs;
              cy_n         = ys;
              frame_done_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
